// File: rtl/enc_pkg.sv
// Shared definitions for the registered priority encoder family.
package enc_pkg;

    localparam int ENC_N_DEFAULT = 4;

    function automatic int enc_iw(input int n);
        return $clog2(n);
    endfunction

    typedef logic [2:0] enc_code_t;

endpackage

// File: rtl/enc_prio_core.sv
// Combinational priority encoder: valid flag plus index of the highest set request bit.
module enc_prio_core
    import enc_pkg::*;
#(
    parameter int N  = ENC_N_DEFAULT,
    parameter int IW = enc_iw(N)
) (
    input  logic [N-1:0] a,
    output logic [IW:0]  c
);

    logic found;

    // Scan from the top bit down; the first hit wins and masks all lower bits.
    always_comb begin
        c     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && a[N-1-i] == 1'b1) begin
                found       = 1'b1;
                c[IW]       = 1'b1;
                c[IW-1:0]   = IW'(N - 1 - i);
            end
        end
    end

endmodule

// File: rtl/enc_reg.sv
// Registered priority encoder: y holds {valid, index} of a, one clock after sampling.
module enc_reg
    import enc_pkg::*;
#(
    parameter int N  = ENC_N_DEFAULT,
    parameter int IW = enc_iw(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  a,
    output logic [IW:0]   y
);

    logic [IW:0] y_d;
    logic [IW:0] y_q;

    enc_prio_core #(
        .N  (N),
        .IW (IW)
    ) u_core (
        .a (a),
        .c (y_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

    a_idx_zero_when_invalid : assert property (@(posedge clk) !y_q[IW] |-> (y_q[IW-1:0] == '0));

endmodule

// File: tb/tb_enc_reg.sv
// Scoreboard bench for enc_reg: stimulus pushes expected codes, a monitor pops and compares after each edge.
module tb_enc_reg;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [2:0] y;

    int n_checks;
    int n_fail;

    logic [2:0] exp_q[$];
    string      name_q[$];
    logic [2:0] prev_exp;

    enc_reg #(
        .N (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference written as an explicit priority chain, independent of the RTL loop.
    function automatic logic [2:0] ref_enc(input logic [3:0] v);
        if (v[3])      return 3'b111;
        else if (v[2]) return 3'b110;
        else if (v[1]) return 3'b101;
        else if (v[0]) return 3'b100;
        else           return 3'b000;
    endfunction

    task automatic check(input string nm, input logic [2:0] act, input logic [2:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: y=%b expected=%b", nm, act, req);
        end
    endtask

    // Drive one cycle of stimulus between edges and queue the result due after the next edge.
    task automatic step(input logic [3:0] av, input logic rv, input logic [2:0] ev, input string nm);
        @(negedge clk);
        a     = av;
        rst_n = rv;
        if (!rv) begin
            #1;
            check({nm, "_hold_before_edge"}, y, prev_exp);
        end
        exp_q.push_back(ev);
        name_q.push_back(nm);
        prev_exp = ev;
    endtask

    initial begin : monitor
        logic [2:0] e;
        string      s;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                s = name_q.pop_front();
                check(s, y, e);
            end
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: y=%b expected=end_of_test", y);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [3:0] v;
        int         waited;
        n_checks = 0;
        n_fail   = 0;
        prev_exp = 3'b000;
        a        = 4'b1111;
        rst_n    = 1'b0;

        step(4'b1111, 1'b0, 3'b000, "reset0");
        step(4'b1111, 1'b0, 3'b000, "reset1");
        step(4'b1111, 1'b1, 3'b111, "reset_release");

        step(4'b0001, 1'b1, 3'b100, "single0");
        step(4'b0010, 1'b1, 3'b101, "single1");
        step(4'b0100, 1'b1, 3'b110, "single2");
        step(4'b1000, 1'b1, 3'b111, "single3");

        step(4'b1111, 1'b1, 3'b111, "mask1111");
        step(4'b1010, 1'b1, 3'b111, "mask1010");
        step(4'b1100, 1'b1, 3'b111, "mask1100");
        step(4'b0011, 1'b1, 3'b101, "mask0011");

        step(4'b1000, 1'b1, 3'b111, "pre_empty");
        step(4'b0000, 1'b1, 3'b000, "empty");

        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            if (i == 9)
                step(v, 1'b0, 3'b000, "sweep_reset");
            else
                step(v, 1'b1, ref_enc(v), $sformatf("sweep_%0d", i));
        end
        step(4'b1111, 1'b1, 3'b111, "post_sweep");
        step(4'b0000, 1'b1, 3'b000, "tail");

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
